// File: rtl/rsa_modexp_engine.sv
// rtl/rsa_modexp_engine.sv - RSA modular exponentiation engine computing data^k mod N
// Right-to-left square-and-multiply, one exponent bit per cycle, valid/ready on both sides.
module rsa_modexp_engine #(
   parameter int unsigned W     = 16,
   parameter int unsigned N     = 3233,
   parameter int unsigned E     = 17,
   parameter int unsigned D     = 2753,
   parameter int unsigned EXP_W = 12
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_err,
   output logic         busy
);

   localparam int unsigned CW = $clog2(EXP_W + 1);
   localparam logic [W-1:0]     N_W      = W'(N);
   localparam logic [2*W-1:0]   N_2W     = (2*W)'(N);
   localparam logic [EXP_W-1:0] E_X      = EXP_W'(E);
   localparam logic [EXP_W-1:0] D_X      = EXP_W'(D);
   localparam logic [CW-1:0]    CNT_INIT = CW'(EXP_W);
   localparam logic [CW-1:0]    CNT_LAST = CW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     base_q, result_q;
   logic [EXP_W-1:0] exp_q;
   logic [CW-1:0]    cnt_q;
   logic             err_q;
   logic             accept, in_range;
   logic [2*W-1:0]   mul_rb, mul_bb;
   logic [W-1:0]     rb_mod, bb_mod;

   assign accept   = in_valid && in_ready;
   assign in_range = (in_data < N_W);

   // Full 2W-bit products so reduction never sees a truncated value.
   assign mul_rb = {{W{1'b0}}, result_q} * {{W{1'b0}}, base_q};
   assign mul_bb = {{W{1'b0}}, base_q} * {{W{1'b0}}, base_q};
   assign rb_mod = W'(mul_rb % N_2W);
   assign bb_mod = W'(mul_bb % N_2W);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = in_range ? RUN : DONE;
         RUN:  if (cnt_q == CNT_LAST) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) && reset_n;
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      out_data  = result_q;
      out_err   = err_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q   <= '0;
         result_q <= '0;
         exp_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else if (state == IDLE && accept) begin
         if (!in_range) begin
            result_q <= '0;
            err_q    <= 1'b1;
         end else begin
            base_q   <= in_data;
            result_q <= W'(1);
            exp_q    <= in_mode ? E_X : D_X;
            cnt_q    <= CNT_INIT;
            err_q    <= 1'b0;
         end
      end else if (state == RUN) begin
         if (exp_q[0]) result_q <= rb_mod;
         base_q <= bb_mod;
         exp_q  <= exp_q >> 1;
         cnt_q  <= cnt_q - CNT_LAST;
      end
   end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb/tb_rsa_modexp_engine.sv - directed self-checking bench for rsa_modexp_engine
module tb_rsa_modexp_engine;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   rsa_modexp_engine #(.W(16), .N(3233), .E(17), .D(2753), .EXP_W(12)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // lat = rising edges after the accept edge before out_valid is seen.
   task automatic run_op(input logic [15:0] d, input logic m,
                         output logic [15:0] r, output logic e, output int lat);
      @(negedge clk);
      in_data  = d;
      in_mode  = m;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = out_data;
      e = out_err;
      if (out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [15:0] r, r2;
      logic        e, e2;
      int          lat, lat2;
      logic [15:0] held;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_err", out_err, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);

      run_op(16'd65, 1'b1, r, e, lat);
      check("enc65_data", r, 2790);
      check("enc65_err", e, 0);
      check("enc65_latency", lat, 12);
      check("enc65_idle_after", in_ready, 1);

      run_op(16'd2790, 1'b0, r, e, lat);
      check("dec2790_data", r, 65);
      check("dec2790_latency", lat, 12);

      // Error operand: DONE entered at the accept edge itself, so out_valid is
      // already high in the very next cycle.
      run_op(16'd3233, 1'b1, r, e, lat);
      check("err_data", r, 0);
      check("err_flag", e, 1);
      check("err_latency", lat, 0);

      run_op(16'd0, 1'b1, r, e, lat);
      check("zero_data", r, 0);
      check("zero_err", e, 0);
      run_op(16'd1, 1'b1, r, e, lat);
      check("one_data", r, 1);
      run_op(16'd3232, 1'b0, r, e, lat);
      check("nm1_dec_data", r, 3232);
      check("nm1_dec_err", e, 0);
      run_op(16'd3232, 1'b1, r, e, lat);
      check("nm1_enc_data", r, 3232);
      run_op(16'd2, 1'b1, r, e, lat);
      check("enc2_data", r, 1752);

      for (int v = 0; v < 256; v++) begin
         run_op(v[15:0], 1'b1, r, e, lat);
         run_op(r, 1'b0, r2, e2, lat2);
         check($sformatf("sweep_%0d", v), r2, v);
      end

      out_ready = 1'b0;
      run_op(16'd65, 1'b1, r, e, lat);
      check("bp_first_data", r, 2790);
      held = out_data;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", out_valid, 1);
         check("bp_out_data", out_data, held);
         check("bp_out_err", out_err, 0);
         check("bp_in_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);

      @(negedge clk);
      in_data  = 16'd65;
      in_mode  = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         if (out_valid) break;
         check("stab_in_ready", in_ready, 0);
         in_data = 16'($urandom_range(0, 4000));
         in_mode = ~in_mode;
         lat++;
      end
      in_valid = 1'b0;
      check("stab_data", out_data, 2790);
      check("stab_latency", lat, 12);
      @(posedge clk);
      #1;
      check("stab_back_idle", in_ready, 1);

      @(negedge clk);
      in_data  = 16'd65;
      in_mode  = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_busy_before", busy, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_op(16'd65, 1'b1, r, e, lat);
      check("post_rst_data", r, 2790);
      check("post_rst_latency", lat, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
